// File: rtl/serializer_unit_cell_32x8.sv
// 8-lane, 32-bit parallel-to-serial cell: round-robin lane capture, LSB-first serial output.
// Define USE_POWER_PINS_EN to expose VPWR/VGND for gate-level/post-APR simulation.
module serializer_unit_cell_32x8 #(
   parameter int WIDTH = 32,
   parameter int LANES = 8
) (
`ifdef USE_POWER_PINS_EN
   inout  wire              VPWR,
   inout  wire              VGND,
`endif
   input  logic             CLK,
   input  logic             RESET,
   input  logic [WIDTH-1:0] PAR_IN1,
   input  logic [WIDTH-1:0] PAR_IN2,
   input  logic [WIDTH-1:0] PAR_IN3,
   input  logic [WIDTH-1:0] PAR_IN4,
   input  logic [WIDTH-1:0] PAR_IN5,
   input  logic [WIDTH-1:0] PAR_IN6,
   input  logic [WIDTH-1:0] PAR_IN7,
   input  logic [WIDTH-1:0] PAR_IN8,
   output logic             SERIAL_OUT
);

   localparam int CNT_W  = $clog2(WIDTH);
   localparam int LANE_W = $clog2(LANES);
   localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(WIDTH - 1);
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

   logic [CNT_W-1:0]  bit_cnt;
   logic [LANE_W-1:0] lane_sel;
   logic [WIDTH-2:0]  sreg;
   logic [WIDTH-1:0]  lane_word;

   always_comb begin
      lane_word = '0;
      case (lane_sel)
         3'd0:    lane_word = PAR_IN1;
         3'd1:    lane_word = PAR_IN2;
         3'd2:    lane_word = PAR_IN3;
         3'd3:    lane_word = PAR_IN4;
         3'd4:    lane_word = PAR_IN5;
         3'd5:    lane_word = PAR_IN6;
         3'd6:    lane_word = PAR_IN7;
         3'd7:    lane_word = PAR_IN8;
         default: lane_word = '0;
      endcase
   end

   // The lane word is only consumed at frame start; bits 1..WIDTH-1 then live in sreg.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         bit_cnt    <= '0;
         lane_sel   <= '0;
         sreg       <= '0;
         SERIAL_OUT <= 1'b0;
      end else begin
         if (bit_cnt == '0) begin
            SERIAL_OUT <= lane_word[0];
            sreg       <= lane_word[WIDTH-1:1];
         end else begin
            SERIAL_OUT <= sreg[0];
            sreg       <= {1'b0, sreg[WIDTH-2:1]};
         end
         if (bit_cnt == LAST_BIT) begin
            bit_cnt  <= '0;
            lane_sel <= (lane_sel == LAST_LANE) ? '0 : lane_sel + 1'b1;
         end else begin
            bit_cnt <= bit_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_serializer_unit_cell_32x8.sv
// Directed bench for serializer_unit_cell_32x8: reset, pattern, lane rotation,
// mid-frame input change, mid-frame reset and a set of fixed-seed random words.
module tb_serializer_unit_cell_32x8;

   logic        CLK;
   logic        RESET;
   logic [31:0] par_in [8];
   logic        SERIAL_OUT;

   int total = 0;
   int bad   = 0;

   serializer_unit_cell_32x8 dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .PAR_IN1    (par_in[0]),
      .PAR_IN2    (par_in[1]),
      .PAR_IN3    (par_in[2]),
      .PAR_IN4    (par_in[3]),
      .PAR_IN5    (par_in[4]),
      .PAR_IN6    (par_in[5]),
      .PAR_IN7    (par_in[6]),
      .PAR_IN8    (par_in[7]),
      .SERIAL_OUT (SERIAL_OUT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Advance one edge and settle before anyone samples or drives.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_all(input logic [31:0] w);
      for (int n = 0; n < 8; n++) par_in[n] = w;
   endtask

   // Collect one 32-bit frame; bit i is the value seen after the i-th edge.
   task automatic get_frame(output logic [31:0] w);
      w = '0;
      for (int i = 0; i < 32; i++) begin
         tick();
         w[i] = SERIAL_OUT;
      end
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      tick();
      tick();
      RESET = 1'b0;
   endtask

   logic [31:0] w;
   logic [31:0] rnd;

   initial begin
      RESET = 1'b1;
      set_all(32'hFFFF_FFFF);

      // Reset held two clocks with all-ones lanes
      tick();
      chk("reset_edge1", {31'd0, SERIAL_OUT}, 32'd0);
      tick();
      chk("reset_edge2", {31'd0, SERIAL_OUT}, 32'd0);

      // Single pattern, two back-to-back frames
      set_all(32'hF5A3_0000);
      RESET = 1'b0;
      get_frame(w);
      chk("pattern_f1", w, 32'hF5A3_0000);
      get_frame(w);
      chk("pattern_f2", w, 32'hF5A3_0000);

      // Lane rotation: one-hot per lane, then lane 1 again
      do_reset();
      for (int n = 0; n < 8; n++) par_in[n] = 32'h1 << n;
      for (int n = 0; n < 8; n++) begin
         get_frame(w);
         chk($sformatf("rot_lane%0d", n + 1), w, 32'h1 << n);
      end
      get_frame(w);
      chk("rot_wrap_lane1", w, 32'h0000_0001);

      // Mid-frame change of lane 1 must not disturb the current frame
      do_reset();
      set_all(32'h0);
      par_in[0] = 32'hAAAA_AAAA;
      w = '0;
      for (int i = 0; i < 32; i++) begin
         if (i == 10) par_in[0] = 32'h0;
         tick();
         w[i] = SERIAL_OUT;
      end
      chk("midchg_lane1", w, 32'hAAAA_AAAA);
      for (int n = 1; n < 8; n++) begin
         get_frame(w);
         chk($sformatf("midchg_lane%0d", n + 1), w, 32'h0);
      end
      get_frame(w);
      chk("midchg_lane1_next", w, 32'h0);

      // Mid-frame reset during lane 3
      do_reset();
      par_in[0] = 32'hDEAD_BEEF;
      par_in[1] = 32'h1234_5678;
      par_in[2] = 32'hFFFF_FFFF;
      for (int n = 3; n < 8; n++) par_in[n] = 32'h5555_5555;
      get_frame(w);
      chk("mrst_lane1", w, 32'hDEAD_BEEF);
      get_frame(w);
      chk("mrst_lane2", w, 32'h1234_5678);
      w = '0;
      for (int i = 0; i < 17; i++) begin
         tick();
         w[i] = SERIAL_OUT;
      end
      chk("mrst_lane3_partial", w, 32'h0001_FFFF);
      RESET = 1'b1;
      tick();
      chk("mrst_out_zero", {31'd0, SERIAL_OUT}, 32'd0);
      RESET = 1'b0;
      get_frame(w);
      chk("mrst_restart_lane1", w, 32'hDEAD_BEEF);

      // Random words, all lanes equal, fixed seed
      do_reset();
      rnd = $urandom(32'h5EED_0001);
      for (int k = 0; k < 10; k++) begin
         rnd = $urandom;
         set_all(rnd);
         get_frame(w);
         chk($sformatf("rand%0d", k), w, rnd);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard stop in case the stimulus ever stalls.
   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/serializer_unit_cell_32x8.md
Name: serializer_unit_cell_32x8

Overview:
- 8-lane, 32-bit parallel-to-serial unit cell.
- Each frame, one lane's word is captured and shifted out LSB-first on a single serial line, one bit per clock.
- Lanes are visited round-robin: lane 1..8, then wrap.
- Sits at the TX edge of the serdes datapath; instantiated as a hard cell (post-APR netlist with optional power pins).

Parameters:
- WIDTH, 32, bits per parallel word (= serial frame length in clocks).
- LANES, 8, number of parallel input lanes; ports fixed at PAR_IN1..PAR_IN8, so LANES=8 in this cell.

Ports:
- CLK  input  1  rising-edge clock, one serial bit per cycle.
- RESET  input  1  synchronous, active-high reset.
- PAR_IN1..PAR_IN8  input  32 each  parallel lane words; bit 0 is transmitted first.
- SERIAL_OUT  output  1  registered serial data.
- VPWR, VGND  inout  1 each  power/ground; present only with USE_POWER_PINS_EN.

Behaviour:
- Internal state:
  - bit_cnt, 5 bits, 0..WIDTH-1.
  - lane_sel, 3 bits, 0..7, selects PAR_IN(lane_sel+1).
  - sreg, WIDTH-1 bits, shift register.
- Reset: on a rising CLK edge with RESET=1, bit_cnt=0, lane_sel=0, sreg=0, SERIAL_OUT=0.
  - Reset asserted mid-frame aborts the frame at that edge; no partial-frame completion.
- Normal edge (RESET=0):
  - If bit_cnt==0 (frame start):
    - Sample the selected lane word W.
    - SERIAL_OUT <= W[0]; sreg <= W[31:1].
  - Else: SERIAL_OUT <= sreg[0]; sreg <= sreg >> 1 (zero fill).
  - bit_cnt <= bit_cnt+1, wrapping 31->0.
  - When bit_cnt==31, lane_sel <= lane_sel+1, wrapping 7->0.
- Latency: bit k of a word sampled at edge E appears on SERIAL_OUT immediately after edge E+k, for k=0..31.
  - First edge after reset release samples PAR_IN1.
- Output is continuous: frames are back-to-back with no idle or gap bits.
  - A full 8-lane round takes 256 clocks.
- PAR_INx is sampled only at frame start.
  - Changes mid-frame do not affect the current frame.
  - Non-selected lanes are never sampled.
- SERIAL_OUT is a flop output, glitch-free, with no combinational path from PAR_IN.
- X on a lane word propagates only to the bits of that frame.

Optional Feature:
- USE_POWER_PINS_EN defined:
  - Module exposes inout VPWR and VGND, for connection to supply1/supply0 in gate-level/post-APR simulation.
  - Logic is unchanged.
- Undefined: no power ports; ports are CLK, RESET, PAR_IN1..8, SERIAL_OUT only.

Test Plan:
- Reset: hold RESET=1 for 2 clocks with all PAR_IN = 32'hFFFFFFFF -> SERIAL_OUT=0 throughout reset.
- Single pattern:
  - Stimulus: release reset; all lanes = bit-reverse of 32'h0000C5AF, i.e. 32'hF5A30000.
  - Required: 64 consecutive SERIAL_OUT bits = two repeats of 0000000000000000_1100010110101111.
- Lane rotation:
  - Stimulus: PAR_INn = 32'h1 << (n-1).
  - Required: over 256 clocks, lane n's frame shows a single 1 at bit position n-1; then lane 1 repeats.
- Mid-frame change:
  - Stimulus: change PAR_IN1 from 32'hAAAAAAAA to 32'h0 at bit 10 of lane 1's frame.
  - Required: the full 0101...0101 alternating frame (LSB first) still emits; the new value appears only at lane 1's next frame, 256 clocks later.
- Mid-frame reset:
  - Stimulus: assert RESET at bit 17 of lane 3's frame.
  - Required: SERIAL_OUT=0 after that edge; after release, the next frame samples PAR_IN1 starting at bit 0.
- Random:
  - Stimulus: 10 random 32-bit words, all lanes equal.
  - Required: each 32-bit serial frame equals the word, LSB first.
